// File: rtl/mips_mem_pkg.sv
// Shared definitions for the 16-bit MIPS data-memory side: DMA state encoding,
// halfword stride and the address bits the data memory actually decodes.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } dma_state_t;

    localparam int HALF_STEP      = 2;
    localparam int MEM_DECODE_LSB = 1;
    localparam int MEM_DECODE_MSB = 8;

endpackage

// File: rtl/mem_copy_dma.sv
// Block-copy initiator: alternates READ/WRITE halfword accesses on the data-memory
// port from src to dst, then pulses done. Outputs are zero when idle so ports can be OR-muxed.
module mem_copy_dma
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_access_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_en,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(1);
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(HALF_STEP);

    dma_state_t        state_reg, state_next;
    logic [ADDR_W-1:0] src_ptr_reg;
    logic [ADDR_W-1:0] dst_ptr_reg;
    logic [LEN_W-1:0]  remaining_reg;
    logic [DATA_W-1:0] data_q_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = (length != '0) ? READ : DONE;
                end
            end
            READ: begin
                state_next = abort ? IDLE : WRITE;
            end
            WRITE: begin
                // Abort beats completion: the final write still commits, but no done pulse.
                if (abort) begin
                    state_next = IDLE;
                end else if (remaining_reg == LEN_W'(1)) begin
                    state_next = DONE;
                end else begin
                    state_next = READ;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            src_ptr_reg   <= '0;
            dst_ptr_reg   <= '0;
            remaining_reg <= '0;
            data_q_reg    <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        src_ptr_reg   <= src_addr & ALIGN_MASK;
                        dst_ptr_reg   <= dst_addr & ALIGN_MASK;
                        remaining_reg <= length;
                    end
                end
                READ: begin
                    data_q_reg <= mem_read_data;
                end
                WRITE: begin
                    src_ptr_reg   <= src_ptr_reg + STEP;
                    dst_ptr_reg   <= dst_ptr_reg + STEP;
                    remaining_reg <= remaining_reg - LEN_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        busy            = 1'b0;
        done            = 1'b0;
        mem_read        = 1'b0;
        mem_write_en    = 1'b0;
        mem_access_addr = '0;
        mem_write_data  = '0;
        case (state_reg)
            READ: begin
                busy            = 1'b1;
                mem_read        = 1'b1;
                mem_access_addr = src_ptr_reg;
            end
            WRITE: begin
                busy            = 1'b1;
                mem_write_en    = 1'b1;
                mem_access_addr = dst_ptr_reg;
                mem_write_data  = data_q_reg;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Bench for mem_copy_dma: a 256-halfword memory model plus a reference copy
// computed halfword by halfword, compared after each directed or random copy.
module tb_mem_copy_dma;
    import mips_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] src_addr = '0;
    logic [15:0] dst_addr = '0;
    logic [7:0]  length = '0;
    logic        busy, done, mem_write_en, mem_read;
    logic [15:0] mem_access_addr, mem_write_data, mem_read_data;

    logic [15:0] mem      [0:255];
    logic [15:0] load_img [0:255];
    logic [15:0] ref_mem  [0:255];
    logic        load_pulse = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    mem_copy_dma #(.ADDR_W(16), .DATA_W(16), .LEN_W(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .abort           (abort),
        .src_addr        (src_addr),
        .dst_addr        (dst_addr),
        .length          (length),
        .busy            (busy),
        .done            (done),
        .mem_access_addr (mem_access_addr),
        .mem_write_data  (mem_write_data),
        .mem_write_en    (mem_write_en),
        .mem_read        (mem_read),
        .mem_read_data   (mem_read_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load_pulse) mem <= load_img;
        else if (mem_write_en) mem[mem_access_addr[MEM_DECODE_MSB:MEM_DECODE_LSB]] <= mem_write_data;
    end

    assign mem_read_data = mem[mem_access_addr[MEM_DECODE_MSB:MEM_DECODE_LSB]];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load_mem();
        for (int i = 0; i < 256; i++) load_img[i] = ref_mem[i];
        @(negedge clk);
        load_pulse = 1'b1;
        @(negedge clk);
        load_pulse = 1'b0;
    endtask

    // Reference: forward halfword copy, each read seeing all earlier writes.
    task automatic apply_model(input logic [15:0] s, input logic [15:0] d, input int cnt);
        int si, di;
        si = int'(s) >> 1;
        di = int'(d) >> 1;
        for (int i = 0; i < cnt; i++) ref_mem[(di + i) % 256] = ref_mem[(si + i) % 256];
    endtask

    task automatic check_mem(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
        check({tag, "_mem"}, 64'(bad), 64'd0);
    endtask

    task automatic do_copy(input logic [15:0] s, input logic [15:0] d, input int n,
                           input int abort_j, input int rst_j, input string tag);
        int busy_cnt, done_cnt, done_idx, rd_cnt, wr_cnt, port_bad, written, exp_rd;
        busy_cnt = 0; done_cnt = 0; done_idx = -1; rd_cnt = 0; wr_cnt = 0; port_bad = 0;
        @(negedge clk);
        src_addr = s; dst_addr = d; length = 8'(n); start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        src_addr = 16'($urandom); dst_addr = 16'($urandom); length = 8'($urandom);
        for (int j = 0; j < 2 * n + 3; j++) begin
            @(negedge clk);
            if (j == rst_j) begin
                rst_n = 1'b0;
                #1;
                check({tag, "_rst_outputs"},
                      64'({busy, done, mem_read, mem_write_en, mem_access_addr, mem_write_data}), 64'd0);
                break;
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_idx < 0) done_idx = j;
            end
            if (mem_read) rd_cnt++;
            if (mem_write_en) wr_cnt++;
            if ((!mem_read && !mem_write_en && mem_access_addr != 16'd0) ||
                (!mem_write_en && mem_write_data != 16'd0) || (mem_read && mem_write_en))
                port_bad++;
            if (j == abort_j) abort = 1'b1;
            if (j == 1 && n >= 1) start = 1'b1;
            @(posedge clk);
            #1;
            abort = 1'b0;
            start = 1'b0;
        end
        if (rst_j >= 0) begin
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            written = rst_j / 2;
        end else begin
            if (abort_j >= 0) begin
                written = (abort_j + 1) / 2;
                exp_rd  = abort_j / 2 + 1;
                check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(abort_j + 1));
                check({tag, "_done_count"}, 64'(done_cnt), 64'd0);
            end else begin
                written = n;
                exp_rd  = n;
                check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(2 * n));
                check({tag, "_done_count"}, 64'(done_cnt), 64'd1);
                check({tag, "_done_cycle"}, 64'(done_idx), 64'(2 * n));
            end
            check({tag, "_reads"}, 64'(rd_cnt), 64'(exp_rd));
            check({tag, "_writes"}, 64'(wr_cnt), 64'(written));
            check({tag, "_port_zero"}, 64'(port_bad), 64'd0);
        end
        apply_model(s, d, written);
        check_mem(tag);
        $display("[TB] copy %s src=%04h dst=%04h len=%0d halfwords_written=%0d", tag, s, d, n, written);
    endtask

    initial begin
        int n, aj;
        logic [15:0] s, d;
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_outputs",
              64'({busy, done, mem_read, mem_write_en, mem_access_addr, mem_write_data}), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 256; i++) ref_mem[i] = 16'($urandom);
        ref_mem[8'h10] = 16'h00A1; ref_mem[8'h11] = 16'h00B2;
        ref_mem[8'h12] = 16'h00C3; ref_mem[8'h13] = 16'h00D4;
        load_mem();

        do_copy(16'h0020, 16'h0080, 4, -1, -1, "basic4");
        check("basic4_d0", 64'(mem[8'h40]), 64'h00A1);
        check("basic4_d3", 64'(mem[8'h43]), 64'h00D4);

        do_copy(16'h0010, 16'h0040, 0, -1, -1, "len0");
        do_copy(16'h0021, 16'h0041, 1, -1, -1, "odd");

        ref_mem[8'hFF] = 16'h1111;
        ref_mem[8'h00] = 16'h2222;
        load_mem();
        do_copy(16'h01FE, 16'h0100, 2, -1, -1, "wrap");
        check("wrap_d0", 64'(mem[8'h80]), 64'h1111);
        check("wrap_d1", 64'(mem[8'h81]), 64'h2222);

        do_copy(16'h0020, 16'h0060, 4, 3, -1, "abort");
        do_copy(16'h0040, 16'h00A0, 3, -1, 2, "reset");
        do_copy(16'h0030, 16'h00C0, 1, -1, -1, "after_rst");

        for (int k = 0; k < 12; k++) begin
            n = int'($urandom_range(0, 12));
            s = 16'($urandom);
            d = (k % 3 == 0) ? s + 16'(2 * $urandom_range(1, 4)) : 16'($urandom);
            aj = (k % 4 == 3 && n > 0) ? int'($urandom_range(0, 2 * n - 1)) : -1;
            do_copy(s, d, n, aj, -1, $sformatf("rand%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_copy_dma.md
# mem_copy_dma

Block-copy initiator that drives the data-memory port of the 16-bit MIPS datapath. Given a source byte address, destination byte address and halfword count, it issues alternating read and write accesses to copy the block, then pulses `done`. It sits beside the load/store stage. A top-level mux gives it the data-memory port while `busy` is high.

## Interface
Parameters:
- `ADDR_W`, 16: byte-address width.
- `DATA_W`, 16: halfword width.
- `LEN_W`, 8: width of the halfword-count field.

Ports:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request a copy; sampled only in IDLE.
- `abort` in 1: cancel an active copy.
- `src_addr` in ADDR_W: source byte address; bit 0 is ignored.
- `dst_addr` in ADDR_W: destination byte address; bit 0 is ignored.
- `length` in LEN_W: number of halfwords to copy; 0 is legal.
- `busy` out 1: high while in READ or WRITE.
- `done` out 1: one-cycle pulse on completion.
- `mem_access_addr` out ADDR_W: memory byte address.
- `mem_write_data` out DATA_W: memory write data.
- `mem_write_en` out 1: memory write strobe; memory writes on the rising edge.
- `mem_read` out 1: memory read enable; memory returns read data combinationally.
- `mem_read_data` in DATA_W: memory read data.

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - On `start`, latch `src_addr & ~1`, `dst_addr & ~1` and `length` into `src_ptr`, `dst_ptr` and `remaining`.
  - Go to READ if `length != 0`, otherwise go to DONE.
- READ:
  - Drive `mem_read=1` and `mem_access_addr=src_ptr`.
  - Capture `mem_read_data` into `data_q` on the closing edge.
  - Go to WRITE.
- WRITE:
  - Drive `mem_write_en=1`, `mem_access_addr=dst_ptr` and `mem_write_data=data_q`.
  - On the closing edge: `src_ptr+=2`, `dst_ptr+=2`, `remaining-=1`.
  - Go to DONE if `remaining==1`, otherwise go to READ.
- DONE: `done=1` for exactly one cycle, then go to IDLE.
- Outputs outside active states:
  - `mem_read` and `mem_write_en` are 0 in IDLE and DONE.
  - `mem_access_addr` and `mem_write_data` are 0 whenever the corresponding enable is 0, so the top-level mux may OR ports.
- Pointer arithmetic:
  - Pointers wrap modulo 2^ADDR_W.
  - Memory decodes address bits [8:1], so blocks wrap within 512 bytes; no error is flagged.
- Overlap: copy is strictly forward. `dst[i]` receives the value held at `src+2i` at the time of its READ cycle; overlapping blocks with `dst > src` propagate data, by design.
- `start` while not IDLE is ignored; its inputs are not latched.
- `abort` in READ or WRITE:
  - The next state is IDLE, with no `done` pulse.
  - A WRITE in progress on that cycle still commits, because the strobe is already asserted.
  - `abort` in IDLE or DONE has no effect.
- `abort` and the last WRITE in the same cycle: abort wins and `done` is not pulsed, but the final write commits.
- Reset mid-copy:
  - Immediate return to IDLE with all outputs 0.
  - A partially copied block is left as is.
- Reset values: state IDLE; `busy`, `done`, `mem_read`, `mem_write_en` = 0; `mem_access_addr`, `mem_write_data` = 0; pointers, `remaining` and `data_q` = 0.

## Timing
- Let E0 be the edge at which `start` is sampled; N = `length`.
- READ occupies the cycles after E0, E2, …, E(2N-2); WRITE occupies the cycles after E1, E3, …, E(2N-1).
- Halfword i is written at edge E(2i+2).
- `done` is high in the cycle after E(2N), and `busy` is high from E0 to E(2N).
- Total: 2N cycles busy plus 1 cycle done; the earliest next start is sampled at E(2N+2).
- N=0: `done` is high in the cycle after E0 and `busy` never rises.
- All outputs are Moore functions of state and registers; there are no combinational paths from input to output. `mem_read_data` is used only at the register input.

## Structure
- Shared package `mips_mem_pkg`:
  - state enum `dma_state_t` {IDLE, READ, WRITE, DONE};
  - `HALF_STEP = 2`;
  - `MEM_DECODE_LSB = 1`, `MEM_DECODE_MSB = 8`.
- Single module; no sub-module is warranted.
- Pointer and count registers live in one sequential process; output decode lives in one combinational process.

## Test plan
- Preload memory word index 0x10..0x13 (bytes 0x20..0x26) with A1,B2,C3,D4; start with src=0x0020, dst=0x0080, len=4 → bytes 0x80..0x86 read A1,B2,C3,D4. `done` is pulsed once, 9 cycles after the start edge; `busy` is high for 8 cycles.
- len=0, src=0x0010, dst=0x0040 → `done` in the cycle after start, `busy` stays 0, no `mem_write_en`.
- Odd src=0x0021, dst=0x0041, len=1 → reads byte 0x20 and writes byte 0x40.
- Wrap: src=0x01FE, len=2, memory 0x1FE=0x1111 and 0x000=0x2222, dst=0x0100 → 0x100=0x1111 and 0x102=0x2222.
- Assert `abort` in the second WRITE of a len=4 copy → exactly 2 halfwords are written, no `done`, IDLE next cycle. A `start` pulse while busy is ignored.
- Assert `rst_n` low mid-READ → all outputs 0 immediately. After release, a new len=1 copy completes normally.
